// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into press / release / long-press events and
// serialises them round-robin onto a single valid/ready event port.
module button_event_scheduler #(
    parameter int NUM_BTN    = 4,
    parameter int ID_W       = 2,
    parameter int TICK_DIV   = 12000,
    parameter int HOLD_TICKS = 500,
    parameter int HOLD_W     = 10
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_in,
    input  logic                evt_ready,
    input  logic                clear_overrun,
    output logic                evt_valid,
    output logic [ID_W-1:0]     evt_id,
    output logic [1:0]          evt_code,
    output logic [NUM_BTN-1:0]  btn_state,
    output logic [NUM_BTN-1:0]  overrun
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    localparam logic [1:0] T_PRESS = 2'd0;
    localparam logic [1:0] T_LONG  = 2'd1;
    localparam logic [1:0] T_REL   = 2'd2;

    function automatic logic [1:0] next_type(input logic [1:0] t);
        return (t == T_REL) ? T_PRESS : t + 2'd1;
    endfunction

    function automatic logic [1:0] code_of(input logic [1:0] t);
        case (t)
            T_PRESS: code_of = 2'b01;
            T_LONG:  code_of = 2'b11;
            default: code_of = 2'b10;
        endcase
    endfunction

    logic [NUM_BTN-1:0]       sync1;
    logic [NUM_BTN-1:0]       prev;
    logic [TICK_W-1:0]        tick_cnt;
    logic                     tick;
    logic [HOLD_W-1:0]        hold_cnt [NUM_BTN];
    logic [NUM_BTN-1:0]       fired;
    logic [NUM_BTN-1:0]       press_b;
    logic [NUM_BTN-1:0]       rel_b;
    logic [NUM_BTN-1:0]       long_b;
    logic [NUM_BTN-1:0][2:0]  new_evt;
    logic [NUM_BTN-1:0][2:0]  pend;
    logic [NUM_BTN-1:0][2:0]  clr;
    logic [NUM_BTN-1:0]       ovr_set;
    logic [1:0]               last_type [NUM_BTN];
    logic [ID_W-1:0]          last_grant;
    logic                     load_en;
    logic                     found;
    int                       sel;
    logic [1:0]               sel_type;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            btn_state <= '0;
            prev      <= '0;
            tick_cnt  <= '0;
        end else begin
            sync1     <= btn_in;
            btn_state <= sync1;
            prev      <= btn_state;
            tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        press_b = btn_state & ~prev;
        rel_b   = ~btn_state & prev;
        long_b  = '0;
        new_evt = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            long_b[b]  = btn_state[b] & ~press_b[b] & ~fired[b] & tick &
                         (hold_cnt[b] == HOLD_LAST);
            new_evt[b] = {rel_b[b], long_b[b], press_b[b]};
        end
    end

    // Hold counter stops once the long-press fires; re-armed only by release or a new press.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            fired <= '0;
            for (int b = 0; b < NUM_BTN; b++) hold_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if (press_b[b] || !btn_state[b]) begin
                    hold_cnt[b] <= '0;
                    fired[b]    <= 1'b0;
                end else if (tick && !fired[b]) begin
                    hold_cnt[b] <= hold_cnt[b] + HOLD_W'(1);
                    if (hold_cnt[b] == HOLD_LAST) fired[b] <= 1'b1;
                end
            end
        end
    end

    assign load_en = ~evt_valid | evt_ready;

    // Events of one button cycle press -> long -> release, so the oldest pending
    // event is the first set bit after the last one emitted for that button.
    always_comb begin
        int idx;
        logic [1:0] t0, t1, t2;
        found    = 1'b0;
        sel      = 0;
        sel_type = T_PRESS;
        idx      = 0;
        for (int i = 1; i <= NUM_BTN; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_BTN) idx = idx - NUM_BTN;
            if (!found && (|pend[idx])) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        t0 = next_type(last_type[sel]);
        t1 = next_type(t0);
        t2 = next_type(t1);
        if (pend[sel][t0])      sel_type = t0;
        else if (pend[sel][t1]) sel_type = t1;
        else                    sel_type = t2;
        clr = '0;
        if (load_en && found) clr[sel][sel_type] = 1'b1;
        for (int b = 0; b < NUM_BTN; b++)
            ovr_set[b] = |(new_evt[b] & pend[b] & ~clr[b]);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            overrun <= '0;
        end else begin
            pend    <= (pend & ~clr) | new_evt;
            overrun <= (clear_overrun ? '0 : overrun) | ovr_set;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_code   <= '0;
            last_grant <= ID_W'(NUM_BTN - 1);
            for (int b = 0; b < NUM_BTN; b++) last_type[b] <= T_REL;
        end else if (load_en) begin
            if (found) begin
                evt_valid      <= 1'b1;
                evt_id         <= ID_W'(sel);
                evt_code       <= code_of(sel_type);
                last_grant     <= ID_W'(sel);
                last_type[sel] <= sel_type;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: press/release/long-press events,
// back-pressure, overrun, async reset and round-robin fairness.
module tb_button_event_scheduler;

    logic       clock_in = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic       evt_ready;
    logic       clear_overrun;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [1:0] evt_code;
    logic [3:0] btn_state;
    logic [3:0] overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int q_id[$];
    int q_code[$];
    int q_cyc[$];

    button_event_scheduler #(
        .NUM_BTN(4), .ID_W(2), .TICK_DIV(4), .HOLD_TICKS(3), .HOLD_W(2)
    ) dut (
        .clock_in(clock_in),
        .reset(reset),
        .btn_in(btn_in),
        .evt_ready(evt_ready),
        .clear_overrun(clear_overrun),
        .evt_valid(evt_valid),
        .evt_id(evt_id),
        .evt_code(evt_code),
        .btn_state(btn_state),
        .overrun(overrun)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc++;

    // Record every handshake; inputs only change 1 ns after a rising edge.
    always @(negedge clock_in) begin
        if (!reset && evt_valid && evt_ready) begin
            q_id.push_back(int'(evt_id));
            q_code.push_back(int'(evt_code));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        if (obs !== expd) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clock_in);
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        q_id.delete(); q_code.delete(); q_cyc.delete();
    endtask

    task automatic clear_q();
        q_id.delete(); q_code.delete(); q_cyc.delete();
    endtask

    initial begin
        int bad, n_long, long_cyc;
        int exp_id4[5]   = '{0, 1, 0, 1, 1};
        int exp_code4[5] = '{1, 1, 2, 2, 2};

        reset = 1'b1; btn_in = '0; evt_ready = 1'b1; clear_overrun = 1'b0;
        step(3);
        check_val("rst_valid", evt_valid, 0);
        check_val("rst_id", evt_id, 0);
        check_val("rst_code", evt_code, 0);
        check_val("rst_state", btn_state, 0);
        check_val("rst_ovr", overrun, 0);
        reset = 1'b0;
        step(2);

        // 1: short press then release, latency 4 edges
        clear_q();
        btn_in[2] = 1'b1;
        step(3);
        check_val("t1_not_yet", evt_valid, 0);
        step(1);
        check_val("t1_valid", evt_valid, 1);
        check_val("t1_id", evt_id, 2);
        check_val("t1_code", evt_code, 1);
        step(1);
        btn_in[2] = 1'b0;
        step(10);
        check_val("t1_count", q_id.size(), 2);
        check_val("t1_rel_id", q_id[1], 2);
        check_val("t1_rel_code", q_code[1], 2);

        // 2: long hold produces exactly one long-press
        clear_q();
        btn_in[1] = 1'b1;
        step(20);
        btn_in[1] = 1'b0;
        step(8);
        n_long = 0; long_cyc = 0;
        foreach (q_code[i]) if (q_code[i] == 3) begin n_long++; long_cyc = q_cyc[i]; end
        check_val("t2_count", q_id.size(), 3);
        check_val("t2_press", q_code[0], 1);
        check_val("t2_id", q_id[0], 1);
        check_val("t2_nlong", n_long, 1);
        check_val("t2_long_lat", ((long_cyc - q_cyc[0]) >= 9) && ((long_cyc - q_cyc[0]) <= 12), 1);
        check_val("t2_rel", q_code[2], 2);

        // 3: back-pressure holds output stable; simultaneous presses drain back to back
        reset_dut();
        evt_ready = 1'b0;
        btn_in = 4'b1001;
        step(4);
        check_val("t3_valid", evt_valid, 1);
        bad = 0;
        repeat (10) begin
            step(1);
            if (!(evt_valid && evt_id == 2'd0 && evt_code == 2'b01)) bad++;
        end
        check_val("t3_stable", bad, 0);
        evt_ready = 1'b1;
        step(4);
        check_val("t3_first", q_id[0], 0);
        check_val("t3_second", q_id[1], 3);
        check_val("t3_second_code", q_code[1], 1);
        check_val("t3_b2b", q_cyc[1] - q_cyc[0], 1);
        btn_in = '0;
        step(12);

        // 4: overrun on a repeated press while the output is blocked
        reset_dut();
        evt_ready = 1'b0;
        btn_in[0] = 1'b1; step(2);
        btn_in[0] = 1'b0; step(4);
        btn_in[1] = 1'b1; step(2);
        btn_in[1] = 1'b0; step(2);
        check_val("t4_ovr_pre", overrun, 0);
        btn_in[1] = 1'b1; step(4);
        check_val("t4_ovr", overrun, 4'b0010);
        check_val("t4_state", btn_state, 4'b0010);
        clear_overrun = 1'b1; step(1);
        clear_overrun = 1'b0;
        check_val("t4_ovr_clr", overrun, 0);
        evt_ready = 1'b1;
        step(1);
        btn_in[1] = 1'b0;
        step(12);
        check_val("t4_count", q_id.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t4_id%0d", i), q_id[i], exp_id4[i]);
            check_val($sformatf("t4_code%0d", i), q_code[i], exp_code4[i]);
        end

        // 5: async reset with events queued, held buttons re-press afterwards
        clear_q();
        evt_ready = 1'b0;
        btn_in = 4'b1100;
        step(6);
        check_val("t5_pre_valid", evt_valid, 1);
        @(posedge clock_in);
        #3 reset = 1'b1;
        #1;
        check_val("t5_async_valid", evt_valid, 0);
        check_val("t5_async_code", evt_code, 0);
        check_val("t5_async_state", btn_state, 0);
        check_val("t5_async_ovr", overrun, 0);
        step(2);
        reset = 1'b0;
        evt_ready = 1'b1;
        clear_q();
        step(8);
        check_val("t5_count", q_id.size(), 2);
        check_val("t5_id0", q_id[0], 2);
        check_val("t5_code0", q_code[0], 1);
        check_val("t5_id1", q_id[1], 3);
        btn_in = '0;
        step(10);

        // 6: all buttons together, twice: grants rotate 0,1,2,3
        reset_dut();
        btn_in = 4'hF; step(8);
        btn_in = 4'h0; step(8);
        btn_in = 4'hF; step(8);
        btn_in = 4'h0; step(8);
        check_val("t6_count", q_id.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("t6_id%0d", i), q_id[i], i % 4);
            check_val($sformatf("t6_code%0d", i), q_code[i], ((i / 4) % 2 == 0) ? 1 : 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
